// File: rtl/conv_3x3_ctrl_pkg.sv
// Shared constants for the 3x3 convolution controller: state encoding,
// tap count and output FIFO geometry.
package conv_3x3_ctrl_pkg;

    localparam int unsigned N_TAP      = 9;
    localparam int unsigned TAP_BW     = 4;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned CNT_BW     = 2;
    localparam int unsigned ST_BW      = 3;

    typedef logic [ST_BW-1:0] state_t;

    localparam logic [ST_BW-1:0] ST_IDLE   = 3'd0;
    localparam logic [ST_BW-1:0] ST_LOAD_W = 3'd1;
    localparam logic [ST_BW-1:0] ST_RUN    = 3'd2;
    localparam logic [ST_BW-1:0] ST_DRAIN  = 3'd3;
    localparam logic [ST_BW-1:0] ST_DONE   = 3'd4;

    localparam logic [TAP_BW-1:0] LAST_TAP = TAP_BW'(N_TAP - 1);

endpackage

// File: rtl/conv_3x3_ctrl_fifo.sv
// Two-entry result FIFO. Entry 0 is always the head, so the head data and
// the not-empty flag come straight from flops.
module conv_3x3_ctrl_fifo
    import conv_3x3_ctrl_pkg::*;
#(
    parameter int unsigned O_BW = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [O_BW-1:0]   din,
    input  logic              pop,
    output logic [O_BW-1:0]   head,
    output logic              not_empty,
    output logic [CNT_BW-1:0] count
);

    logic [O_BW-1:0] data0;
    logic [O_BW-1:0] data1;
    logic            valid0;
    logic            valid1;
    logic            pop_ok;

    assign pop_ok = pop & valid0;

    // Entries shift toward slot 0 on pop; push lands in the first free slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data0  <= '0;
            data1  <= '0;
            valid0 <= 1'b0;
            valid1 <= 1'b0;
        end else begin
            case ({push, pop_ok})
                2'b11: begin
                    if (valid1) begin
                        data0 <= data1;
                        data1 <= din;
                    end else begin
                        data0 <= din;
                    end
                end
                2'b01: begin
                    data0  <= data1;
                    valid0 <= valid1;
                    valid1 <= 1'b0;
                end
                2'b10: begin
                    if (!valid0) begin
                        data0  <= din;
                        valid0 <= 1'b1;
                    end else if (!valid1) begin
                        data1  <= din;
                        valid1 <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head      = data0;
    assign not_empty = valid0;
    assign count     = CNT_BW'(valid0) + CNT_BW'(valid1);

endmodule

// File: rtl/conv_3x3_ctrl.sv
// 3x3 convolution sequencer: loads 9 weights, streams activations to an
// external MAC datapath and collects one result per window into a FIFO.
module conv_3x3_ctrl
    import conv_3x3_ctrl_pkg::*;
#(
    parameter int unsigned X_BW  = 8,
    parameter int unsigned W_BW  = 8,
    parameter int unsigned O_BW  = 19,
    parameter int unsigned LAT   = 5,
    parameter int unsigned NW_BW = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [NW_BW-1:0]       i_num_win,
    input  logic                   i_w_valid,
    output logic                   o_w_ready,
    input  logic signed [W_BW-1:0] i_w,
    input  logic                   i_x_valid,
    output logic                   o_x_ready,
    input  logic signed [X_BW-1:0] i_x,
    output logic                   o_pe_valid,
    output logic                   o_pe_first,
    output logic signed [X_BW-1:0] o_pe_x,
    output logic signed [W_BW-1:0] o_pe_w,
    input  logic signed [O_BW-1:0] i_pe_y,
    output logic                   o_y_valid,
    input  logic                   i_y_ready,
    output logic signed [O_BW-1:0] o_y,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int unsigned INF_BW = $clog2(LAT + 2) + 1;

    state_t                 state;
    state_t                 state_nxt;
    logic [TAP_BW-1:0]      tap;
    logic [TAP_BW-1:0]      tap_nxt;
    logic [NW_BW-1:0]       win_cnt;
    logic [NW_BW-1:0]       win_cnt_nxt;
    logic [NW_BW-1:0]       num_win;
    logic [NW_BW-1:0]       num_win_nxt;
    logic signed [W_BW-1:0] w [N_TAP];
    logic [LAT-1:0]         sr;
    logic [LAT-1:0]         sr_nxt;
    logic                   pe_last;
    logic                   pe_last_nxt;
    logic                   w_hs;
    logic                   x_hs;
    logic                   w_load;
    logic                   y_push;
    logic                   y_pop;
    logic [CNT_BW-1:0]      fifo_cnt;
    logic [INF_BW-1:0]      infl_nxt;
    logic [INF_BW-1:0]      fifo_nxt;
    logic                   x_ready_nxt;
    logic                   w_ready_nxt;
    logic                   busy_nxt;
    logic                   done_nxt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counters and next-cycle handshake/status flags.
    always_comb begin
        state_nxt   = state;
        tap_nxt     = tap;
        win_cnt_nxt = win_cnt;
        num_win_nxt = num_win;
        pe_last_nxt = 1'b0;
        w_load      = 1'b0;
        w_hs        = o_w_ready & i_w_valid;
        x_hs        = o_x_ready & i_x_valid;

        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_nxt   = ST_LOAD_W;
                    num_win_nxt = i_num_win;
                    tap_nxt     = '0;
                    win_cnt_nxt = '0;
                end
            end
            ST_LOAD_W: begin
                if (w_hs) begin
                    w_load = 1'b1;
                    if (tap == LAST_TAP) begin
                        tap_nxt   = '0;
                        state_nxt = ST_RUN;
                    end else begin
                        tap_nxt = tap + TAP_BW'(1);
                    end
                end
            end
            ST_RUN: begin
                if (num_win == '0) begin
                    state_nxt = ST_DRAIN;
                end else if (x_hs) begin
                    if (tap == LAST_TAP) begin
                        tap_nxt     = '0;
                        win_cnt_nxt = win_cnt + NW_BW'(1);
                        pe_last_nxt = 1'b1;
                        if (win_cnt == num_win - NW_BW'(1)) begin
                            state_nxt = ST_DRAIN;
                        end
                    end else begin
                        tap_nxt = tap + TAP_BW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (!o_pe_valid && (sr == '0) && (fifo_cnt == '0)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        sr_nxt    = sr << 1;
        sr_nxt[0] = pe_last;
        y_push    = sr[LAT-1];
        y_pop     = o_y_valid & i_y_ready;

        // Credit: windows that will occupy a FIFO slot once they retire.
        infl_nxt = INF_BW'(pe_last_nxt);
        for (int unsigned i = 0; i < LAT; i++) begin
            infl_nxt = infl_nxt + INF_BW'(sr_nxt[i]);
        end
        fifo_nxt = INF_BW'(fifo_cnt) + INF_BW'(y_push) - INF_BW'(y_pop);

        x_ready_nxt = (state_nxt == ST_RUN) && (num_win_nxt != '0)
                      && ((infl_nxt + fifo_nxt) < INF_BW'(FIFO_DEPTH));
        w_ready_nxt = (state_nxt == ST_LOAD_W);
        busy_nxt    = (state_nxt != ST_IDLE);
        done_nxt    = (state_nxt == ST_DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tap        <= '0;
            win_cnt    <= '0;
            num_win    <= '0;
            sr         <= '0;
            pe_last    <= 1'b0;
            o_pe_valid <= 1'b0;
            o_pe_first <= 1'b0;
            o_pe_x     <= '0;
            o_pe_w     <= '0;
            o_w_ready  <= 1'b0;
            o_x_ready  <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            for (int unsigned i = 0; i < N_TAP; i++) begin
                w[i] <= '0;
            end
        end else begin
            tap        <= tap_nxt;
            win_cnt    <= win_cnt_nxt;
            num_win    <= num_win_nxt;
            sr         <= sr_nxt;
            pe_last    <= pe_last_nxt;
            o_w_ready  <= w_ready_nxt;
            o_x_ready  <= x_ready_nxt;
            o_busy     <= busy_nxt;
            o_done     <= done_nxt;
            o_pe_valid <= x_hs;
            if (w_load) begin
                w[tap] <= i_w;
            end
            if (x_hs) begin
                o_pe_x     <= i_x;
                o_pe_w     <= w[tap];
                o_pe_first <= (tap == '0);
            end
        end
    end

    conv_3x3_ctrl_fifo #(
        .O_BW (O_BW)
    ) u_fifo (
        .clk       (i_clk),
        .rst       (i_rst),
        .push      (y_push),
        .din       (i_pe_y),
        .pop       (y_pop),
        .head      (o_y),
        .not_empty (o_y_valid),
        .count     (fifo_cnt)
    );

endmodule
